// File: rtl/demux_2_for_5_bits_stream.sv
// rtl/demux_2_for_5_bits_stream.sv - buffered 1-to-2 demultiplexer for register-address tokens
//
// Purpose:
//   Routes one valid/ready token stream to one of two output channels, chosen
//   by in_select. Each channel has its own DEPTH-entry FIFO, so a stalled
//   consumer on one channel never loses tokens or blocks the other channel.
//   A pushed token becomes visible on the next cycle; there is no bypass.
//
// Optional feature macro: DEMUX_STATS_EN
//   When defined, adds count0/count1, which are saturating per-channel
//   counters of accepted tokens.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous reset, active-high (flushes both FIFOs)
//   in_valid    in   input token present
//   in_ready    out  selected channel not full (independent of in_valid)
//   in_data     in   input token
//   in_select   in   destination channel (0/1)
//   out0_valid  out  channel 0 head valid
//   out0_ready  in   channel 0 consumer takes head
//   out0_data   out  channel 0 head token (0 when not valid)
//   out1_valid  out  channel 1 head valid
//   out1_ready  in   channel 1 consumer takes head
//   out1_data   out  channel 1 head token (0 when not valid)
//   count0      out  [DEMUX_STATS_EN] tokens accepted into channel 0
//   count1      out  [DEMUX_STATS_EN] tokens accepted into channel 1

module demux_2_for_5_bits_stream #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]      count0,
    output logic [15:0]      count1
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    // Per-channel FIFO state, indexed by channel number.
    logic [WIDTH-1:0] r_mem    [2][DEPTH];
    logic [PTR_W-1:0] r_rd_ptr [2];
    logic [PTR_W-1:0] r_wr_ptr [2];
    logic [OCC_W-1:0] r_occ    [2];

    logic [1:0] w_full;
    logic [1:0] w_valid;
    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic [1:0] w_out_ready;

    assign w_out_ready = {out1_ready, out0_ready};

    always_comb begin
        w_full  = '0;
        w_valid = '0;
        for (int k = 0; k < 2; k++) begin
            w_full[k]  = (r_occ[k] == FULL_OCC);
            w_valid[k] = (r_occ[k] != '0);
        end
    end

    // Ready depends only on the selected channel's occupancy; a pop on a full
    // channel in the same cycle does not open it, keeping in_ready registered-only.
    assign in_ready = ~w_full[in_select];

    assign w_push[0] = in_valid & in_ready & ~in_select;
    assign w_push[1] = in_valid & in_ready &  in_select;
    assign w_pop     = w_valid & w_out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                r_rd_ptr[k] <= '0;
                r_wr_ptr[k] <= '0;
                r_occ[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_push[k]) begin
                    r_wr_ptr[k] <= r_wr_ptr[k] + PTR_W'(1);
                end
                if (w_pop[k]) begin
                    r_rd_ptr[k] <= r_rd_ptr[k] + PTR_W'(1);
                end
                case ({w_push[k], w_pop[k]})
                    2'b10:   r_occ[k] <= r_occ[k] + OCC_W'(1);
                    2'b01:   r_occ[k] <= r_occ[k] - OCC_W'(1);
                    default: r_occ[k] <= r_occ[k];
                endcase
            end
        end
    end

    // Storage is deliberately not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (w_push[k]) begin
                r_mem[k][r_wr_ptr[k]] <= in_data;
            end
        end
    end

    assign out0_valid = w_valid[0];
    assign out1_valid = w_valid[1];
    assign out0_data  = w_valid[0] ? r_mem[0][r_rd_ptr[0]] : '0;
    assign out1_data  = w_valid[1] ? r_mem[1][r_rd_ptr[1]] : '0;

`ifdef DEMUX_STATS_EN
    logic [15:0] r_count0;
    logic [15:0] r_count1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count0 <= '0;
            r_count1 <= '0;
        end else begin
            if (w_push[0] && (r_count0 != 16'hFFFF)) begin
                r_count0 <= r_count0 + 16'd1;
            end
            if (w_push[1] && (r_count1 != 16'hFFFF)) begin
                r_count1 <= r_count1 + 16'd1;
            end
        end
    end

    assign count0 = r_count0;
    assign count1 = r_count1;
`endif

endmodule
